// File: rtl/phase_calc_pkg.sv
// Shared constants and types for the multi-channel phase shift calculator.
package phase_calc_pkg;
  localparam int PH_W_DEF = 32;
  localparam int T_W_DEF  = 32;
  localparam int CH_IDX_W = 4;

  typedef logic [PH_W_DEF-1:0] phase_t;

  // Control word that travels alongside the data through each pipeline stage.
  typedef struct packed {
    logic                vld;
    logic [CH_IDX_W-1:0] ch;
  } stage_ctl_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/phase_shift_calc_mc_if.sv
// Request/result bus of the phase shift calculator; master drives requests, slave returns results.
interface phase_shift_calc_mc_if
  import phase_calc_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int PH_W   = PH_W_DEF,
  parameter int T_W    = T_W_DEF
);
  localparam int CH_W = ch_w(CH_NUM);

  logic            req_valid;
  logic            req_ready;
  logic [CH_W-1:0] req_ch;
  logic [PH_W-1:0] freq;
  logic [PH_W-1:0] current_phase;
  logic [PH_W-1:0] desired_phase;
  logic [T_W-1:0]  time_from_start;
  logic [PH_W-1:0] max_shift;
  logic            res_valid;
  logic [CH_W-1:0] res_ch;
  logic [PH_W-1:0] res_shift;
  logic            res_clamped;
  logic            req_err;

  modport master (
    output req_valid, req_ch, freq, current_phase, desired_phase, time_from_start, max_shift,
    input  req_ready, res_valid, res_ch, res_shift, res_clamped, req_err
  );

  modport slave (
    input  req_valid, req_ch, freq, current_phase, desired_phase, time_from_start, max_shift,
    output req_ready, res_valid, res_ch, res_shift, res_clamped, req_err
  );
endinterface

// File: rtl/phase_shift_calc_mc_pipe.sv
// Three-stage shift pipeline: inc = freq*time, fut = cur+inc, shift = des-fut (mod 2^PH_W).
// Optional clamp of the final shift when PHASE_SHIFT_LIMIT_EN is defined.
module phase_shift_pipe
  import phase_calc_pkg::*;
#(
  parameter int PH_W = PH_W_DEF,
  parameter int T_W  = T_W_DEF,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_vld,
  input  logic [CH_W-1:0] in_ch,
  input  logic [PH_W-1:0] freq,
  input  logic [T_W-1:0]  time_from_start,
  input  logic [PH_W-1:0] current_phase,
  input  logic [PH_W-1:0] desired_phase,
  input  logic [PH_W-1:0] max_shift,
  output logic            out_vld,
  output logic [CH_W-1:0] out_ch,
  output logic [PH_W-1:0] out_shift,
  output logic            out_clamped
);
  stage_ctl_t      s1_ctl, s2_ctl, s3_ctl;
  logic [PH_W-1:0] s1_inc, s1_cur, s1_des;
  logic [PH_W-1:0] s2_fut, s2_des;
  logic [PH_W-1:0] s3_shift;
  logic            s3_clamped;
  logic [PH_W-1:0] diff, shift_c;
  logic            clamp_hit;

  assign diff = s2_des - s2_fut;

`ifdef PHASE_SHIFT_LIMIT_EN
  logic signed [PH_W:0] diff_x, max_x;
  always_comb begin
    diff_x    = {diff[PH_W-1], diff};
    max_x     = {1'b0, max_shift};
    shift_c   = diff;
    clamp_hit = 1'b0;
    if (diff_x > max_x) begin
      shift_c   = max_shift;
      clamp_hit = 1'b1;
    end else if (diff_x < -max_x) begin
      shift_c   = -max_shift;
      clamp_hit = 1'b1;
    end
  end
`else
  logic unused_max_shift;
  assign unused_max_shift = ^max_shift;
  assign shift_c   = diff;
  assign clamp_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_ctl     <= '0;
      s2_ctl     <= '0;
      s3_ctl     <= '0;
      s1_inc     <= '0;
      s1_cur     <= '0;
      s1_des     <= '0;
      s2_fut     <= '0;
      s2_des     <= '0;
      s3_shift   <= '0;
      s3_clamped <= 1'b0;
    end else begin
      s1_ctl     <= '{vld: in_vld && !flush, ch: CH_IDX_W'(in_ch)};
      s2_ctl     <= '{vld: s1_ctl.vld && !flush, ch: s1_ctl.ch};
      s3_ctl     <= '{vld: s2_ctl.vld && !flush, ch: s2_ctl.ch};
      // Time is reduced to PH_W bits first: the product only matters mod 2^PH_W.
      s1_inc     <= freq * PH_W'(time_from_start);
      s1_cur     <= current_phase;
      s1_des     <= desired_phase;
      s2_fut     <= s1_cur + s1_inc;
      s2_des     <= s1_des;
      s3_shift   <= shift_c;
      s3_clamped <= clamp_hit;
    end
  end

  assign out_vld     = s3_ctl.vld;
  assign out_ch      = CH_W'(s3_ctl.ch);
  assign out_shift   = s3_shift;
  assign out_clamped = s3_clamped;
endmodule

// File: rtl/phase_shift_calc_mc.sv
// Multi-channel phase shift calculator: handshake, result register, per-channel shift bank and done flags.
// Define PHASE_SHIFT_LIMIT_EN to clamp results to +/-max_shift.
module phase_shift_calc_mc
  import phase_calc_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int PH_W   = PH_W_DEF,
  parameter int T_W    = T_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [CH_NUM-1:0]            done_clr,
  output logic [CH_NUM-1:0][PH_W-1:0]  ch_shift,
  output logic [CH_NUM-1:0]            ch_done,
  phase_shift_calc_mc_if.slave         bus
);
  localparam int CH_W = ch_w(CH_NUM);

  logic            accept, ch_ok;
  logic            p_vld, p_clamped;
  logic [CH_W-1:0] p_ch;
  logic [PH_W-1:0] p_shift;

  assign bus.req_ready = reset_n && !flush;
  assign accept        = bus.req_valid && bus.req_ready;
  assign ch_ok         = 32'(bus.req_ch) < CH_NUM;

  phase_shift_pipe #(.PH_W(PH_W), .T_W(T_W), .CH_W(CH_W)) u_pipe (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush           (flush),
    .in_vld          (accept && ch_ok),
    .in_ch           (bus.req_ch),
    .freq            (bus.freq),
    .time_from_start (bus.time_from_start),
    .current_phase   (bus.current_phase),
    .desired_phase   (bus.desired_phase),
    .max_shift       (bus.max_shift),
    .out_vld         (p_vld),
    .out_ch          (p_ch),
    .out_shift       (p_shift),
    .out_clamped     (p_clamped)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.res_valid   <= 1'b0;
      bus.res_ch      <= '0;
      bus.res_shift   <= '0;
      bus.res_clamped <= 1'b0;
      bus.req_err     <= 1'b0;
      ch_shift        <= '0;
      ch_done         <= '0;
    end else begin
      bus.req_err   <= accept && !ch_ok;
      // The output register counts as in-flight too, so flush kills it.
      bus.res_valid <= p_vld && !flush;
      if (p_vld) begin
        bus.res_ch      <= p_ch;
        bus.res_shift   <= p_shift;
        bus.res_clamped <= p_clamped;
      end
      for (int i = 0; i < CH_NUM; i++) begin
        if (bus.res_valid && bus.res_ch == CH_W'(i)) begin
          ch_shift[i] <= bus.res_shift;
          ch_done[i]  <= 1'b1;
        end else if (done_clr[i]) begin
          ch_done[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_phase_shift_calc_mc.sv
// Self-checking bench for phase_shift_calc_mc against an arithmetic reference model.
module tb_phase_shift_calc_mc;
  import phase_calc_pkg::*;

  localparam int CH_NUM = 5;
  localparam int CH_W   = 3;
  localparam phase_t MAXS = 32'h1000_0000;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      flush = 1'b0;
  logic [CH_NUM-1:0]         done_clr = '0;
  logic [CH_NUM-1:0][31:0]   ch_shift;
  logic [CH_NUM-1:0]         ch_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  phase_t            m_shift [CH_NUM];
  logic [CH_NUM-1:0] m_done;

  typedef struct {
    int          due;
    logic [2:0]  ch;
    phase_t      shift;
    logic        clamped;
  } exp_t;
  exp_t sb[$];

  phase_shift_calc_mc_if #(.CH_NUM(CH_NUM), .PH_W(32), .T_W(32)) bus ();

  phase_shift_calc_mc #(.CH_NUM(CH_NUM), .PH_W(32), .T_W(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .done_clr (done_clr),
    .ch_shift (ch_shift),
    .ch_done  (ch_done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Future phase = current + freq*time; shift is what remains to desired, all mod 2^32.
  function automatic phase_t model_shift(input phase_t f, input phase_t t, input phase_t c,
                                         input phase_t d, output logic clamped);
    logic [63:0] prod;
    phase_t      s;
    prod    = 64'(f) * 64'(t);
    s       = d - c - prod[31:0];
    clamped = 1'b0;
`ifdef PHASE_SHIFT_LIMIT_EN
    if ($signed(s) > $signed(MAXS)) begin
      s = MAXS; clamped = 1'b1;
    end else if ($signed(s) < -$signed(MAXS)) begin
      s = -MAXS; clamped = 1'b1;
    end
`endif
    return s;
  endfunction

  task automatic drive_req(input logic [2:0] ch, input phase_t f, input phase_t t,
                           input phase_t c, input phase_t d);
    bus.req_valid       = 1'b1;
    bus.req_ch          = ch;
    bus.freq            = f;
    bus.time_from_start = t;
    bus.current_phase   = c;
    bus.desired_phase   = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_req(3'd1, 32'h1234, 32'd7, 32'h0, 32'h5555);
    tick(); tick(); tick();
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.req_ready); end
    n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    n_tests++; if (bus.req_err !== 1'b0) begin n_fail++; $display("FAIL reset_req_err got %b want 0", bus.req_err); end
    n_tests++; if (bus.res_clamped !== 1'b0) begin n_fail++; $display("FAIL reset_res_clamped got %b want 0", bus.res_clamped); end
    n_tests++; if (bus.res_shift !== 32'h0 || bus.res_ch !== 3'd0) begin n_fail++; $display("FAIL reset_res got ch %0d shift %h want 0/0", bus.res_ch, bus.res_shift); end
    n_tests++; if (ch_done !== '0) begin n_fail++; $display("FAIL reset_ch_done got %b want 0", ch_done); end
    n_tests++; if (ch_shift !== '0) begin n_fail++; $display("FAIL reset_ch_shift got %h want 0", ch_shift); end
    bus.req_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b want 1", bus.req_ready); end
    m_done = '0;
    for (int i = 0; i < CH_NUM; i++) m_shift[i] = '0;
  endtask

  task automatic test_directed();
    phase_t exp; logic cl;
    exp = model_shift(32'h0147_AE14, 32'd200, 32'hC000_0000, 32'h0, cl);
`ifndef PHASE_SHIFT_LIMIT_EN
    n_tests++; if (exp !== 32'h4000_0060) begin n_fail++; $display("FAIL model_ref got %h want 40000060", exp); end
`endif
    drive_req(3'd0, 32'h0147_AE14, 32'd200, 32'hC000_0000, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid cycle %0d got %b want 0", k, bus.res_valid); end
      tick();
    end
    n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid cycle 3 got %b want 0", bus.res_valid); end
    tick();
    n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid got %b want 1", bus.res_valid); end
    n_tests++; if (bus.res_shift !== exp || bus.res_ch !== 3'd0) begin n_fail++; $display("FAIL directed_shift got ch %0d %h want ch 0 %h", bus.res_ch, bus.res_shift, exp); end
    n_tests++; if (bus.res_clamped !== cl) begin n_fail++; $display("FAIL directed_clamped got %b want %b", bus.res_clamped, cl); end
    tick();
    n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle got %b want 0", bus.res_valid); end
    m_done[0] = 1'b1; m_shift[0] = exp;
    n_tests++; if (ch_done !== m_done || ch_shift[0] !== exp) begin n_fail++; $display("FAIL directed_bank got done %b sh %h want %b %h", ch_done, ch_shift[0], m_done, exp); end
  endtask

`ifdef PHASE_SHIFT_LIMIT_EN
  task automatic test_clamp();
    drive_req(3'd2, 32'h0, 32'd50, 32'h2000_0000, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (bus.res_valid !== 1'b1 || bus.res_shift !== 32'hF000_0000 || bus.res_clamped !== 1'b1) begin
      n_fail++; $display("FAIL clamp_neg got v %b %h c %b want 1 f0000000 1", bus.res_valid, bus.res_shift, bus.res_clamped); end
    tick();
    m_done[2] = 1'b1; m_shift[2] = 32'hF000_0000;
  endtask
`endif

  task automatic test_back_to_back();
    phase_t exp [4]; phase_t f, t, c, d; logic cl;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        f = $urandom; t = $urandom; c = $urandom; d = $urandom;
        exp[k] = model_shift(f, t, c, d, cl);
        drive_req(3'(k), f, t, c, d);
      end else bus.req_valid = 1'b0;
      tick();
      if (k >= 3 && k <= 6) begin
        n_tests++; if (bus.res_valid !== 1'b1 || bus.res_ch !== 3'(k-3) || bus.res_shift !== exp[k-3]) begin
          n_fail++; $display("FAIL b2b_result k %0d got v %b ch %0d %h want 1 ch %0d %h", k, bus.res_valid, bus.res_ch, bus.res_shift, k-3, exp[k-3]); end
      end else begin
        n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle k %0d got %b want 0", k, bus.res_valid); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      m_shift[i] = exp[i]; m_done[i] = 1'b1;
      n_tests++; if (ch_shift[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_bank ch %0d got %h want %h", i, ch_shift[i], exp[i]); end
    end
    n_tests++; if (ch_done !== m_done) begin n_fail++; $display("FAIL b2b_done got %b want %b", ch_done, m_done); end
  endtask

  task automatic test_done_clr();
    phase_t exp; logic cl;
    done_clr = '1;
    tick();
    done_clr = '0;
    m_done = '0;
    n_tests++; if (ch_done !== '0) begin n_fail++; $display("FAIL clr_all got %b want 0", ch_done); end
    exp = model_shift(32'h10, 32'h20, 32'h3, 32'h4000_0000, cl);
    drive_req(3'd1, 32'h10, 32'h20, 32'h3, 32'h4000_0000);
    tick();
    bus.req_valid = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (bus.res_valid !== 1'b1 || bus.res_ch !== 3'd1) begin n_fail++; $display("FAIL clr_res got v %b ch %0d want 1 ch 1", bus.res_valid, bus.res_ch); end
    done_clr = 5'b00010;
    tick();
    n_tests++; if (ch_done[1] !== 1'b1 || ch_shift[1] !== exp) begin n_fail++; $display("FAIL set_wins got %b %h want 1 %h", ch_done[1], ch_shift[1], exp); end
    tick();
    done_clr = '0;
    n_tests++; if (ch_done[1] !== 1'b0) begin n_fail++; $display("FAIL clr_after got %b want 0", ch_done[1]); end
    m_shift[1] = exp;
  endtask

  task automatic test_random();
    phase_t f, t, c, d, s; logic cl; logic [2:0] ch; bit go;
    for (int k = 0; k < 60; k++) begin
      go = (k < 50) && ($urandom_range(0, 3) != 0);
      if (go) begin
        f = $urandom; t = $urandom_range(0, 100000); c = $urandom; d = $urandom;
        ch = 3'($urandom_range(0, CH_NUM-1));
        s = model_shift(f, t, c, d, cl);
        drive_req(ch, f, t, c, d);
      end else bus.req_valid = 1'b0;
      tick();
      if (go) sb.push_back('{due: cyc + 3, ch: ch, shift: s, clamped: cl});
      if (sb.size() > 0 && sb[0].due == cyc) begin
        n_tests++; if (bus.res_valid !== 1'b1 || bus.res_ch !== sb[0].ch || bus.res_shift !== sb[0].shift || bus.res_clamped !== sb[0].clamped) begin
          n_fail++; $display("FAIL rand_result cyc %0d got v %b ch %0d %h c %b want 1 ch %0d %h c %b", cyc, bus.res_valid, bus.res_ch, bus.res_shift, bus.res_clamped, sb[0].ch, sb[0].shift, sb[0].clamped); end
        m_shift[sb[0].ch] = sb[0].shift; m_done[sb[0].ch] = 1'b1;
        void'(sb.pop_front());
      end else begin
        n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rand_idle cyc %0d got %b want 0", cyc, bus.res_valid); end
      end
    end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL rand_drain got %0d pending want 0", sb.size()); end
    n_tests++; if (ch_done !== m_done) begin n_fail++; $display("FAIL rand_done got %b want %b", ch_done, m_done); end
    for (int i = 0; i < CH_NUM; i++) begin
      n_tests++; if (ch_shift[i] !== m_shift[i]) begin n_fail++; $display("FAIL rand_bank ch %0d got %h want %h", i, ch_shift[i], m_shift[i]); end
    end
  endtask

  task automatic test_err();
    drive_req(CH_W'(CH_NUM), 32'h1, 32'h1, 32'h0, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    n_tests++; if (bus.req_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b want 1", bus.req_err); end
    tick();
    n_tests++; if (bus.req_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got %b want 0", bus.req_err); end
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_result k %0d got %b want 0", k, bus.res_valid); end
      tick();
    end
    n_tests++; if (ch_done !== m_done) begin n_fail++; $display("FAIL err_done got %b want %b", ch_done, m_done); end
  endtask

  task automatic test_flush_reset();
    drive_req(3'd2, 32'h77, 32'h9, 32'h1, 32'h2);
    tick();
    drive_req(3'd3, 32'h5, 32'h6, 32'h7, 32'h8);
    flush = 1'b1;
    #1;
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", bus.req_ready); end
    tick();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop k %0d got %b want 0", k, bus.res_valid); end
      tick();
    end
    drive_req(3'd4, 32'h77, 32'h9, 32'h1, 32'h2);
    tick();
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drop k %0d got %b want 0", k, bus.res_valid); end
      tick();
    end
    n_tests++; if (ch_done !== '0 || ch_shift !== '0 || bus.res_shift !== 32'h0 || bus.res_ch !== 3'd0) begin
      n_fail++; $display("FAIL post_reset got done %b sh %h res %h ch %0d want all 0", ch_done, ch_shift, bus.res_shift, bus.res_ch); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_ch = '0; bus.freq = '0; bus.current_phase = '0;
    bus.desired_phase = '0; bus.time_from_start = '0; bus.max_shift = MAXS;
    test_reset();
    test_directed();
`ifdef PHASE_SHIFT_LIMIT_EN
    test_clamp();
`endif
    test_back_to_back();
    test_done_clr();
    test_random();
    test_err();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
